// File: rtl/led_mode_sched.sv
// led_mode_sched: LED pattern mode controller.
// Arbitrates PS requests, a debounced local pushbutton and an auto-cycle
// timer (priority PS > button > auto).
// Every accepted change is routed through a blanking interval, during which
// mode is forced to 2'b00, before the new mode is applied.
// Optional build macro LED_MODE_SCHED_LOCK_EN adds the ps_lock input. While
// ps_lock is high, button and auto events are suppressed and PS requests
// still pass.
module led_mode_sched #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DWELL_SEC   = 5,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLANK_CYC   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ps_mode,
  input  logic       ps_req,
  input  logic       ps_auto,
`ifdef LED_MODE_SCHED_LOCK_EN
  input  logic       ps_lock,
`endif
  input  logic       btn,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic [1:0] src
);

  localparam longint DWELL_CYC = longint'(DWELL_SEC) * longint'(CLK_FREQ);
  localparam longint DB_CYC    = (longint'(DEBOUNCE_MS) * longint'(CLK_FREQ)) / 64'sd1000;
  localparam longint BL_CYC    = longint'(BLANK_CYC);

  // Counter widths cover 0..terminal; a minimum of one bit keeps degenerate
  // configurations legal.
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int DB_W = (DB_CYC    > 1) ? $clog2(DB_CYC)    : 1;
  localparam int BL_W = (BL_CYC    > 1) ? $clog2(BL_CYC)    : 1;

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [DB_W-1:0] DB_LAST    = (DB_CYC > 0) ? DB_W'(DB_CYC - 1) : '0;
  localparam logic [BL_W-1:0] BL_LAST    = BL_W'(BL_CYC - 1);

  localparam logic [1:0] SRC_RST  = 2'b00;
  localparam logic [1:0] SRC_PS   = 2'b01;
  localparam logic [1:0] SRC_BTN  = 2'b10;
  localparam logic [1:0] SRC_AUTO = 2'b11;

  typedef enum logic {HOLD, BLANK} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [1:0]      psrc_q, psrc_d;
  logic [1:0]      src_d;
  logic [1:0]      mode_d;
  logic            chg_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [BL_W-1:0] blank_q, blank_d;

  logic            btn_s1, btn_s2;
  logic            db_lvl;
  logic [DB_W-1:0] db_cnt;
  logic            btn_evt;

  logic            lock;
  logic            ev_btn, ev_auto, ev_any;
  logic [1:0]      cand, cand_src, auto_next, fin_mode, fin_src;

`ifdef LED_MODE_SCHED_LOCK_EN
  assign lock = ps_lock;
`else
  assign lock = 1'b0;
`endif

  // Synchronise the raw button, debounce it and flag debounced rising edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      db_lvl  <= 1'b0;
      db_cnt  <= '0;
      btn_evt <= 1'b0;
    end else begin
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
      btn_evt <= 1'b0;
      if (btn_s2 != db_lvl) begin
        if (db_cnt == DB_LAST) begin
          db_lvl  <= btn_s2;
          db_cnt  <= '0;
          btn_evt <= btn_s2;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Pick at most one event per cycle and form its candidate mode.
  always_comb begin
    ev_btn    = btn_evt & ~lock;
    ev_auto   = ps_auto & ~lock & (state_q == HOLD) & (dwell_q == DWELL_LAST);
    ev_any    = ps_req | ev_btn | ev_auto;
    auto_next = ((cur_q == 2'b11) || (cur_q == 2'b00)) ? 2'b01 : cur_q + 2'd1;
    cand      = cur_q;
    cand_src  = SRC_PS;
    if (ps_req) begin
      cand     = ps_mode;
      cand_src = SRC_PS;
    end else if (ev_btn) begin
      cand     = cur_q + 2'd1;
      cand_src = SRC_BTN;
    end else if (ev_auto) begin
      cand     = auto_next;
      cand_src = SRC_AUTO;
    end
  end

  // Next-state and output logic for the HOLD/BLANK scheduler.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    psrc_d   = psrc_q;
    src_d    = src;
    mode_d   = mode;
    chg_d    = 1'b0;
    dwell_d  = dwell_q;
    blank_d  = blank_q;
    fin_mode = tgt_q;
    fin_src  = psrc_q;
    case (state_q)
      HOLD: begin
        mode_d = cur_q;
        if (ps_auto && !lock) begin
          dwell_d = dwell_q + DW_W'(1);
        end else begin
          dwell_d = '0;
        end
        if (ev_auto) begin
          dwell_d = '0;
        end
        if (ev_any && (cand != cur_q)) begin
          tgt_d   = cand;
          psrc_d  = cand_src;
          state_d = BLANK;
          blank_d = '0;
          mode_d  = 2'b00;
          dwell_d = '0;
        end
      end
      BLANK: begin
        mode_d  = 2'b00;
        dwell_d = '0;
        // A late event retargets the blank without restarting it.
        if (ev_any) begin
          tgt_d    = cand;
          psrc_d   = cand_src;
          fin_mode = cand;
          fin_src  = cand_src;
        end
        if (blank_q == BL_LAST) begin
          cur_d   = fin_mode;
          src_d   = fin_src;
          mode_d  = fin_mode;
          chg_d   = 1'b1;
          state_d = HOLD;
          blank_d = '0;
        end else begin
          blank_d = blank_q + BL_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HOLD;
      cur_q    <= 2'b00;
      tgt_q    <= 2'b00;
      psrc_q   <= SRC_RST;
      src      <= SRC_RST;
      mode     <= 2'b00;
      mode_chg <= 1'b0;
      dwell_q  <= '0;
      blank_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      psrc_q   <= psrc_d;
      src      <= src_d;
      mode     <= mode_d;
      mode_chg <= chg_d;
      dwell_q  <= dwell_d;
      blank_q  <= blank_d;
    end
  end

endmodule

// File: tb/tb_led_mode_sched.sv
// tb_led_mode_sched: directed bench for led_mode_sched with small timing
// parameters (DWELL_CYC=1000, DB_CYC=5, BLANK_CYC=4).
module tb_led_mode_sched;

  localparam int BLANK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ps_mode = 2'b00;
  logic       ps_req = 1'b0;
  logic       ps_auto = 1'b0;
  logic       btn = 1'b0;
`ifdef LED_MODE_SCHED_LOCK_EN
  logic       ps_lock = 1'b0;
`endif
  logic [1:0] mode;
  logic       mode_chg;
  logic [1:0] src;

  int n_chk = 0;
  int n_pass = 0;

  led_mode_sched #(
    .CLK_FREQ(1000),
    .DWELL_SEC(1),
    .DEBOUNCE_MS(5),
    .BLANK_CYC(BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps_mode(ps_mode),
    .ps_req(ps_req),
    .ps_auto(ps_auto),
`ifdef LED_MODE_SCHED_LOCK_EN
    .ps_lock(ps_lock),
`endif
    .btn(btn),
    .mode(mode),
    .mode_chg(mode_chg),
    .src(src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a PS request and step to the cycle where the change lands.
  task automatic ps_set(input logic [1:0] m);
    ps_mode = m;
    ps_req  = 1'b1;
    tick();
    ps_req  = 1'b0;
    repeat (BLANK) tick();
  endtask

  // Run ncyc cycles with btn high for the first btn_hi of them; record pulses.
  task automatic mon(input int ncyc, input int btn_hi, output int pulses,
                     output logic [1:0] m_at, output logic [1:0] s_at);
    pulses = 0;
    m_at = 2'b00;
    s_at = 2'b00;
    for (int i = 0; i < ncyc; i++) begin
      btn = (i < btn_hi);
      tick();
      ps_req = 1'b0;
      if (mode_chg) begin
        pulses++;
        m_at = mode;
        s_at = src;
      end
    end
    btn = 1'b0;
  endtask

  // Count cycles until the next mode_chg pulse, bounded.
  task automatic wait_chg(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mode_chg && n < 5000);
  endtask

  initial begin
    int pulses;
    int n;
    logic [1:0] m_at, s_at;
    bit seen_chg, seen_mode;

    // Reset state
    tick();
    tick();
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_chg", 32'(mode_chg), 32'd0);
    chk("rst_src", 32'(src), 32'd0);
    rst_n = 1'b1;

    // Idle for 2000 cycles
    seen_chg = 1'b0;
    seen_mode = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (mode_chg) seen_chg = 1'b1;
      if (mode != 2'b00) seen_mode = 1'b1;
    end
    chk("idle_chg", 32'(seen_chg), 32'd0);
    chk("idle_mode", 32'(seen_mode), 32'd0);
    chk("idle_src", 32'(src), 32'd0);

    // PS request to 10: blank N+1..N+4, apply at N+5
    ps_mode = 2'b10;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    for (int i = 1; i <= BLANK; i++) begin
      chk($sformatf("ps_blank_mode_%0d", i), 32'(mode), 32'd0);
      chk($sformatf("ps_blank_chg_%0d", i), 32'(mode_chg), 32'd0);
      tick();
    end
    chk("ps_mode", 32'(mode), 32'd2);
    chk("ps_chg", 32'(mode_chg), 32'd1);
    chk("ps_src", 32'(src), 32'd1);
    tick();
    chk("ps_chg_one_cycle", 32'(mode_chg), 32'd0);

    // Same mode requested again: ignored
    ps_mode = 2'b10;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    seen_chg = 1'b0;
    seen_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mode_chg) seen_chg = 1'b1;
      if (mode != 2'b10) seen_mode = 1'b1;
      tick();
    end
    chk("same_no_pulse", 32'(seen_chg), 32'd0);
    chk("same_no_blank", 32'(seen_mode), 32'd0);

    // Button from mode 11: glitch ignored, press wraps to 00
    ps_set(2'b11);
    chk("pre_btn_mode", 32'(mode), 32'd3);
    mon(15, 3, pulses, m_at, s_at);
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_mode", 32'(mode), 32'd3);
    mon(40, 20, pulses, m_at, s_at);
    chk("btn_pulses", 32'(pulses), 32'd1);
    chk("btn_mode", 32'(m_at), 32'd0);
    chk("btn_src", 32'(s_at), 32'd2);

    // Auto-cycle from 00: 01, 10, 11, 01 every 1004 cycles
    ps_auto = 1'b1;
    wait_chg(n);
    chk("auto1_delay", 32'(n), 32'd1004);
    chk("auto1_mode", 32'(mode), 32'd1);
    chk("auto1_src", 32'(src), 32'd3);
    wait_chg(n);
    chk("auto2_delay", 32'(n), 32'd1004);
    chk("auto2_mode", 32'(mode), 32'd2);
    wait_chg(n);
    chk("auto3_delay", 32'(n), 32'd1004);
    chk("auto3_mode", 32'(mode), 32'd3);
    wait_chg(n);
    chk("auto4_delay", 32'(n), 32'd1004);
    chk("auto4_mode", 32'(mode), 32'd1);
    chk("auto4_src", 32'(src), 32'd3);
    ps_auto = 1'b0;

    // PS and button event in the same cycle: PS wins, button dropped
    ps_set(2'b10);
    chk("pre_tie_mode", 32'(mode), 32'd2);
    btn = 1'b1;
    repeat (7) tick();
    ps_mode = 2'b01;
    ps_req = 1'b1;
    mon(30, 10, pulses, m_at, s_at);
    chk("tie_pulses", 32'(pulses), 32'd1);
    chk("tie_mode", 32'(m_at), 32'd1);
    chk("tie_src", 32'(s_at), 32'd1);

    // PS request during blank retargets without restarting it
    ps_mode = 2'b10;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    ps_mode = 2'b11;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    chk("retgt_blank_mode", 32'(mode), 32'd0);
    tick();
    chk("retgt_blank_chg", 32'(mode_chg), 32'd0);
    tick();
    chk("retgt_chg", 32'(mode_chg), 32'd1);
    chk("retgt_mode", 32'(mode), 32'd3);
    chk("retgt_src", 32'(src), 32'd1);

    // Asynchronous reset in the middle of a blank
    ps_mode = 2'b10;
    ps_req = 1'b1;
    tick();
    ps_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'd0);
    chk("arst_src", 32'(src), 32'd0);
    chk("arst_chg", 32'(mode_chg), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    mon(10, 0, pulses, m_at, s_at);
    chk("arst_hold_pulses", 32'(pulses), 32'd0);
    chk("arst_hold_mode", 32'(mode), 32'd0);

`ifdef LED_MODE_SCHED_LOCK_EN
    // Lock suppresses button and auto, PS still applies
    ps_lock = 1'b1;
    ps_auto = 1'b1;
    mon(1100, 20, pulses, m_at, s_at);
    chk("lock_pulses", 32'(pulses), 32'd0);
    chk("lock_mode", 32'(mode), 32'd0);
    ps_set(2'b10);
    chk("lock_ps_chg", 32'(mode_chg), 32'd1);
    chk("lock_ps_mode", 32'(mode), 32'd2);
    chk("lock_ps_src", 32'(src), 32'd1);
    ps_lock = 1'b0;
    ps_auto = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
